cnn_fwd_sequencer: RTL and testbench
====================================

Name: cnn_fwd_sequencer

Overview:
Top-level sequencing FSM for the CNN forward pass. It walks through two conv-layer stages and then two fully-connected stages. Each conv stage has five steps: weight load, input load, shift/compute, ReLU, pool. Each step is started by a one-hot enable and advances when the matching datapath block reports done. When the whole pass completes, the block asserts done_fwd.

Parameters:
None (state encoding is internal; 14 states, 4-bit binary encoding).

Ports:
clk  input  1  system clock, rising-edge active
reset_n  input  1  asynchronous active-low reset
start_bit  input  1  level request to begin a forward pass
done_w_1  input  1  layer-1 weight load complete
done_i_1  input  1  layer-1 input load complete
done_s_1  input  1  layer-1 shift/compute complete
done_r_1  input  1  layer-1 ReLU complete
done_p_1  input  1  layer-1 pooling complete
done_w_2, done_i_2, done_s_2, done_r_2, done_p_2  input  1 each  same meanings for layer 2
done_fc_1  input  1  FC layer 1 complete
done_fc_2  input  1  FC layer 2 complete
w_load_1, i_load_1, s_load_1, r_load_1, p_load_1  output  1 each  layer-1 step enables
w_load_2, i_load_2, s_load_2, r_load_2, p_load_2  output  1 each  layer-2 step enables
srt_fc_1  output  1  FC1 enable
srt_fc_2  output  1  FC2 enable
done_fwd  output  1  forward pass complete

Behaviour:
- Reset (reset_n=0, asynchronous): state=IDLE; all 13 outputs=0 immediately; reset mid-run aborts to IDLE.
- Outputs are Moore, registered/decoded from state only. At most one output is high at any time.
- State order: IDLE, W1, I1, S1, R1, P1, W2, I2, S2, R2, P2, FC1, FC2, DONE.
- Enable per state:
  - W1 -> w_load_1; I1 -> i_load_1; S1 -> s_load_1; R1 -> r_load_1; P1 -> p_load_1.
  - W2..P2 -> the matching *_load_2.
  - FC1 -> srt_fc_1; FC2 -> srt_fc_2; DONE -> done_fwd.
- Transitions, evaluated at the rising clk edge:
  - IDLE -> W1 when start_bit=1.
  - Each working state -> next state when its own done input is 1. Example: W1 leaves on done_w_1, FC2 leaves on done_fc_2 to DONE. Otherwise it holds.
  - DONE holds with done_fwd=1 while start_bit=1. DONE -> IDLE when start_bit=0.
- Latency:
  - Enable rises one cycle after the edge that samples start_bit or the previous done.
  - Each step takes a minimum of 1 cycle.
  - Minimum pass is 1 (IDLE) + 12 states + DONE, i.e. done_fwd high 13 cycles after start is sampled with all dones held high.
- Done inputs are sampled only in their own state. They may be level signals held high indefinitely; stale high dones for later steps are ignored until that state is reached. A done already high on entry advances the FSM after exactly one cycle in that state.
- Done inputs that are unknown/undriven outside their state must not affect the FSM. Unreachable state encodings return to IDLE.
- start_bit changes during a pass are ignored until DONE.

Test Plan:
- Reset: hold reset_n=0 with start_bit=1 -> all outputs 0, FSM stays IDLE. Release reset_n with start_bit=0 -> stays IDLE.
- Full pass, staggered: 20 ns clock. Raise start_bit, then each done 2–4 cycles apart in order, each held high -> enables appear one at a time in order w_load_1..p_load_1, w_load_2..p_load_2, srt_fc_1, srt_fc_2, then done_fwd=1 and held.
- Back-to-back: all done inputs tied 1, pulse start_bit high -> each enable high for exactly 1 cycle; done_fwd rises 13 cycles after start is sampled.
- Out-of-order dones: assert done_p_2 and done_fc_1 while in W1 -> no advance. Assert done_w_1 -> moves to I1 only.
- Restart: in DONE, drop start_bit to 0 -> done_fwd=0, IDLE next cycle. Raise again -> w_load_1=1.
- Async reset mid-run: assert reset_n=0 while s_load_2=1, between clock edges -> all outputs 0 immediately. The next pass starts from W1.

Source files
------------

// File: rtl/cnn_fwd_sequencer_if.sv
// ---------------------------------------------------------------------------
// cnn_fwd_sequencer_if
//
// Purpose:
//   Bundles the request/done/enable wires between the CNN forward-pass
//   sequencer and the datapath blocks it drives.
//
// Signals:
//   start_bit                         level request to begin a forward pass
//   done_{w,i,s,r,p}_1                layer-1 step completion flags
//   done_{w,i,s,r,p}_2                layer-2 step completion flags
//   done_fc_1, done_fc_2              fully-connected stage completion flags
//   {w,i,s,r,p}_load_1                layer-1 step enables
//   {w,i,s,r,p}_load_2                layer-2 step enables
//   srt_fc_1, srt_fc_2                fully-connected stage enables
//   done_fwd                          forward pass complete
//
// Modports:
//   master  - the side that requests passes and reports step completion
//   slave   - the sequencer itself
// ---------------------------------------------------------------------------
interface cnn_fwd_sequencer_if;

  logic start_bit;

  logic done_w_1;
  logic done_i_1;
  logic done_s_1;
  logic done_r_1;
  logic done_p_1;

  logic done_w_2;
  logic done_i_2;
  logic done_s_2;
  logic done_r_2;
  logic done_p_2;

  logic done_fc_1;
  logic done_fc_2;

  logic w_load_1;
  logic i_load_1;
  logic s_load_1;
  logic r_load_1;
  logic p_load_1;

  logic w_load_2;
  logic i_load_2;
  logic s_load_2;
  logic r_load_2;
  logic p_load_2;

  logic srt_fc_1;
  logic srt_fc_2;
  logic done_fwd;

  modport master (
    output start_bit,
    output done_w_1, done_i_1, done_s_1, done_r_1, done_p_1,
    output done_w_2, done_i_2, done_s_2, done_r_2, done_p_2,
    output done_fc_1, done_fc_2,
    input  w_load_1, i_load_1, s_load_1, r_load_1, p_load_1,
    input  w_load_2, i_load_2, s_load_2, r_load_2, p_load_2,
    input  srt_fc_1, srt_fc_2, done_fwd
  );

  modport slave (
    input  start_bit,
    input  done_w_1, done_i_1, done_s_1, done_r_1, done_p_1,
    input  done_w_2, done_i_2, done_s_2, done_r_2, done_p_2,
    input  done_fc_1, done_fc_2,
    output w_load_1, i_load_1, s_load_1, r_load_1, p_load_1,
    output w_load_2, i_load_2, s_load_2, r_load_2, p_load_2,
    output srt_fc_1, srt_fc_2, done_fwd
  );

endinterface

// File: rtl/cnn_fwd_sequencer.sv
// ---------------------------------------------------------------------------
// cnn_fwd_sequencer
//
// Purpose:
//   Top-level sequencing FSM for the CNN forward pass. Walks two conv
//   stages (weight load, input load, shift/compute, ReLU, pool each) and
//   then two fully-connected stages. Each step is started by a one-hot
//   enable and advances when the matching datapath block reports done.
//   When the whole pass completes, done_fwd is held until start_bit drops.
//
// Ports:
//   clk      input   rising-edge system clock
//   reset_n  input   asynchronous active-low reset; clears all enables
//   bus      slave   cnn_fwd_sequencer_if: start_bit, the twelve done
//                    flags in, the twelve step enables and done_fwd out
//
// Notes:
//   - Outputs are Moore: a register loaded with the decode of the next
//     state, so each enable is glitch-free and tracks the current state.
//   - Only the done flag belonging to the current state is looked at, so
//     stale or undriven flags of other steps cannot move the FSM.
// ---------------------------------------------------------------------------
module cnn_fwd_sequencer (
  input  logic                      clk,
  input  logic                      reset_n,
  cnn_fwd_sequencer_if.slave        bus
);

  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_W1   = 4'd1,
    ST_I1   = 4'd2,
    ST_S1   = 4'd3,
    ST_R1   = 4'd4,
    ST_P1   = 4'd5,
    ST_W2   = 4'd6,
    ST_I2   = 4'd7,
    ST_S2   = 4'd8,
    ST_R2   = 4'd9,
    ST_P2   = 4'd10,
    ST_FC1  = 4'd11,
    ST_FC2  = 4'd12,
    ST_DONE = 4'd13
  } state_e;

  // Output vector bit positions
  //   [0] w_load_1  [1] i_load_1  [2] s_load_1  [3] r_load_1  [4] p_load_1
  //   [5] w_load_2  [6] i_load_2  [7] s_load_2  [8] r_load_2  [9] p_load_2
  //   [10] srt_fc_1 [11] srt_fc_2 [12] done_fwd
  localparam int unsigned NUM_OUT = 13;

  state_e               state_q;
  state_e               state_d;
  logic                 step_done_s;
  logic [NUM_OUT-1:0]   out_q;

  // One-hot enable pattern owned by a given state; IDLE and illegal codes drive nothing.
  function automatic logic [NUM_OUT-1:0] decode_outputs(input state_e s);
    logic [NUM_OUT-1:0] v;
    v = 13'd0;
    case (s)
      ST_W1:   v = 13'h0001;
      ST_I1:   v = 13'h0002;
      ST_S1:   v = 13'h0004;
      ST_R1:   v = 13'h0008;
      ST_P1:   v = 13'h0010;
      ST_W2:   v = 13'h0020;
      ST_I2:   v = 13'h0040;
      ST_S2:   v = 13'h0080;
      ST_R2:   v = 13'h0100;
      ST_P2:   v = 13'h0200;
      ST_FC1:  v = 13'h0400;
      ST_FC2:  v = 13'h0800;
      ST_DONE: v = 13'h1000;
      default: v = 13'd0;
    endcase
    return v;
  endfunction

  // Pick the single done flag that the current state is waiting on.
  always_comb begin
    step_done_s = 1'b0;
    case (state_q)
      ST_W1:   step_done_s = bus.done_w_1;
      ST_I1:   step_done_s = bus.done_i_1;
      ST_S1:   step_done_s = bus.done_s_1;
      ST_R1:   step_done_s = bus.done_r_1;
      ST_P1:   step_done_s = bus.done_p_1;
      ST_W2:   step_done_s = bus.done_w_2;
      ST_I2:   step_done_s = bus.done_i_2;
      ST_S2:   step_done_s = bus.done_s_2;
      ST_R2:   step_done_s = bus.done_r_2;
      ST_P2:   step_done_s = bus.done_p_2;
      ST_FC1:  step_done_s = bus.done_fc_1;
      ST_FC2:  step_done_s = bus.done_fc_2;
      default: step_done_s = 1'b0;
    endcase
  end

  // Next-state logic: linear walk through the pass, gated by the selected done.
  // An unknown done or start resolves to the hold/else branch, keeping the
  // FSM in place rather than jumping.
  always_comb begin
    state_d = ST_IDLE;
    case (state_q)
      ST_IDLE: begin
        if (bus.start_bit == 1'b1) state_d = ST_W1;
        else                       state_d = ST_IDLE;
      end
      ST_W1: begin
        if (step_done_s == 1'b1) state_d = ST_I1;
        else                     state_d = ST_W1;
      end
      ST_I1: begin
        if (step_done_s == 1'b1) state_d = ST_S1;
        else                     state_d = ST_I1;
      end
      ST_S1: begin
        if (step_done_s == 1'b1) state_d = ST_R1;
        else                     state_d = ST_S1;
      end
      ST_R1: begin
        if (step_done_s == 1'b1) state_d = ST_P1;
        else                     state_d = ST_R1;
      end
      ST_P1: begin
        if (step_done_s == 1'b1) state_d = ST_W2;
        else                     state_d = ST_P1;
      end
      ST_W2: begin
        if (step_done_s == 1'b1) state_d = ST_I2;
        else                     state_d = ST_W2;
      end
      ST_I2: begin
        if (step_done_s == 1'b1) state_d = ST_S2;
        else                     state_d = ST_I2;
      end
      ST_S2: begin
        if (step_done_s == 1'b1) state_d = ST_R2;
        else                     state_d = ST_S2;
      end
      ST_R2: begin
        if (step_done_s == 1'b1) state_d = ST_P2;
        else                     state_d = ST_R2;
      end
      ST_P2: begin
        if (step_done_s == 1'b1) state_d = ST_FC1;
        else                     state_d = ST_P2;
      end
      ST_FC1: begin
        if (step_done_s == 1'b1) state_d = ST_FC2;
        else                     state_d = ST_FC1;
      end
      ST_FC2: begin
        if (step_done_s == 1'b1) state_d = ST_DONE;
        else                     state_d = ST_FC2;
      end
      ST_DONE: begin
        // Completion is held for as long as the requester keeps start high.
        if (bus.start_bit == 1'b1) state_d = ST_DONE;
        else                       state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; outputs load the decode of the next state so
  // they change on the same edge as the state they describe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      out_q   <= 13'd0;
    end else begin
      state_q <= state_d;
      out_q   <= decode_outputs(state_d);
    end
  end

  assign bus.w_load_1 = out_q[0];
  assign bus.i_load_1 = out_q[1];
  assign bus.s_load_1 = out_q[2];
  assign bus.r_load_1 = out_q[3];
  assign bus.p_load_1 = out_q[4];
  assign bus.w_load_2 = out_q[5];
  assign bus.i_load_2 = out_q[6];
  assign bus.s_load_2 = out_q[7];
  assign bus.r_load_2 = out_q[8];
  assign bus.p_load_2 = out_q[9];
  assign bus.srt_fc_1 = out_q[10];
  assign bus.srt_fc_2 = out_q[11];
  assign bus.done_fwd = out_q[12];

endmodule

// File: tb/tb_cnn_fwd_sequencer.sv
// ---------------------------------------------------------------------------
// tb_cnn_fwd_sequencer
//
// Self-checking bench for cnn_fwd_sequencer. A stage-counter model of the
// pass (stage 0 = idle, 1..12 = steps, 13 = done) predicts the one-hot
// output vector and is compared against the DUT on every falling edge.
// Directed scenarios add literal expectations for reset, ordering, timing,
// out-of-order dones, restart and asynchronous abort.
// ---------------------------------------------------------------------------
module tb_cnn_fwd_sequencer;

  logic        clk;
  logic        reset_n;
  logic        start_r;
  logic [11:0] dn;      // [0]=w1 .. [4]=p1, [5]=w2 .. [9]=p2, [10]=fc1, [11]=fc2
  logic [12:0] act;

  int total;
  int bad;

  int          m_stage;
  logic [12:0] m_exp;

  cnn_fwd_sequencer_if bus ();

  cnn_fwd_sequencer dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  assign bus.start_bit = start_r;
  assign bus.done_w_1  = dn[0];
  assign bus.done_i_1  = dn[1];
  assign bus.done_s_1  = dn[2];
  assign bus.done_r_1  = dn[3];
  assign bus.done_p_1  = dn[4];
  assign bus.done_w_2  = dn[5];
  assign bus.done_i_2  = dn[6];
  assign bus.done_s_2  = dn[7];
  assign bus.done_r_2  = dn[8];
  assign bus.done_p_2  = dn[9];
  assign bus.done_fc_1 = dn[10];
  assign bus.done_fc_2 = dn[11];

  assign act = {bus.done_fwd, bus.srt_fc_2, bus.srt_fc_1,
                bus.p_load_2, bus.r_load_2, bus.s_load_2, bus.i_load_2, bus.w_load_2,
                bus.p_load_1, bus.r_load_1, bus.s_load_1, bus.i_load_1, bus.w_load_1};

  // 20 ns clock
  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Pass model: idle waits for start, step k waits for its own done,
  // done stage stays while start is high.
  function automatic int next_stage(input int s, input logic st, input logic [11:0] d);
    if (s == 0)  return (st === 1'b1) ? 1 : 0;
    if (s == 13) return (st === 1'b1) ? 13 : 0;
    if (d[s-1] === 1'b1) return s + 1;
    return s;
  endfunction

  function automatic logic [12:0] stage_vec(input int s);
    logic [12:0] one;
    one = 13'd1;
    if (s == 0) return 13'd0;
    return one << (s - 1);
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_stage <= 0;
      m_exp   <= 13'd0;
    end else begin
      m_stage <= next_stage(m_stage, start_r, dn);
      m_exp   <= stage_vec(next_stage(m_stage, start_r, dn));
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    total++;
    if (act !== m_exp) begin
      bad++;
      $display("FAIL model_cmp t=%0t: got %h want %h", $time, act, m_exp);
    end
  end

  task automatic chk(input string nm, input logic [12:0] got, input logic [12:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  // Wait (bounded) for output bit k to go high; a timeout counts as a failure.
  task automatic wait_bit(input int k, input string nm);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (act[k] === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL %s: got timeout want bit %0d high", nm, k);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int hi_cnt [13];
    logic [12:0] one;
    total   = 0;
    bad     = 0;
    one     = 13'd1;
    start_r = 1'b1;
    dn      = 12'd0;
    reset_n = 1'b0;

    // Reset held with start high: nothing moves
    repeat (4) @(posedge clk);
    #2 chk("reset_hold", act, 13'd0);
    start_r = 1'b0;
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #2 chk("idle_after_reset", act, 13'd0);

    // Staggered full pass: each done raised 2..4 cycles after its enable
    start_r = 1'b1;
    for (int k = 0; k < 12; k++) begin
      wait_bit(k, "stagger_wait");
      chk("stagger_onehot", act, one << k);
      repeat (2 + (k % 3)) @(posedge clk);
      #2 dn[k] = 1'b1;
    end
    wait_bit(12, "stagger_done_wait");
    repeat (5) @(posedge clk);
    #2 chk("done_hold", act, 13'h1000);

    // Restart: drop start in DONE, then request again with dones cleared
    start_r = 1'b0;
    dn      = 12'd0;
    @(posedge clk);
    #2 chk("restart_idle", act, 13'd0);
    start_r = 1'b1;
    @(posedge clk);
    #2 chk("restart_w1", act, 13'h0001);

    // Out-of-order dones in W1 are ignored
    dn[9]  = 1'b1;
    dn[10] = 1'b1;
    repeat (3) @(posedge clk);
    #2 chk("ooo_hold_w1", act, 13'h0001);
    dn[0] = 1'b1;
    @(posedge clk);
    #2 chk("ooo_to_i1", act, 13'h0002);
    @(posedge clk);
    #2 chk("ooo_i1_hold", act, 13'h0002);

    // Run on to S2, then abort asynchronously between edges
    dn[6:1] = 6'h3F;
    wait_bit(7, "s2_wait");
    #5 reset_n = 1'b0;
    #1 chk("async_reset", act, 13'd0);
    dn = 12'd0;
    @(posedge clk);
    #2 reset_n = 1'b1;
    @(posedge clk);
    #2 chk("post_reset_w1", act, 13'h0001);

    // Back to idle, then back-to-back pass with every done tied high
    reset_n = 1'b0;
    start_r = 1'b0;
    dn      = 12'hFFF;
    @(posedge clk);
    #2 reset_n = 1'b1;
    @(posedge clk);
    #2 chk("b2b_idle", act, 13'd0);
    for (int i = 0; i < 13; i++) hi_cnt[i] = 0;
    start_r = 1'b1;
    n = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #2;
      if (c == 1) start_r = 1'b0;
      for (int i = 0; i < 13; i++) hi_cnt[i] += int'(act[i]);
      if (act[12] === 1'b1) begin
        n = c;
        break;
      end
    end
    total++;
    if (n != 13) begin
      bad++;
      $display("FAIL b2b_latency: got %0d want 13", n);
    end
    for (int i = 0; i < 12; i++) begin
      total++;
      if (hi_cnt[i] != 1) begin
        bad++;
        $display("FAIL b2b_width bit%0d: got %0d want 1", i, hi_cnt[i]);
      end
    end
    @(posedge clk);
    #2 chk("b2b_return_idle", act, 13'd0);
    repeat (2) @(posedge clk);
    #2 chk("b2b_stay_idle", act, 13'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
